// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// ---------------
// Multicycle control FSM for the single-issue RV32I datapath. The opcode,
// funct3 and bit 30 of each instruction are captured in IF, and the
// datapath is then stepped through ID, EX, MEM and WB as the instruction
// class requires. A data-memory access waits for mem_ready for at most
// MEM_WAIT_MAX cycles. An illegal opcode or a memory timeout parks the FSM
// in ERR, which is left only through rst.
//
// Ports:
//   clk        in   1   system clock, all state on rising edge
//   rst        in   1   synchronous, active-high reset
//   instr      in  32   instruction word, sampled in IF only
//   Zero       in   1   ALU zero flag (branch resolution in EX)
//   mem_ready  in   1   data memory completed its access this cycle
//   PCSrc      out  1   1 = PC + branch offset, 0 = PC + 4
//   ALUSrc     out  1   1 = immediate operand, 0 = rs2
//   RegWrite   out  1   register file write enable
//   MemToReg   out  1   1 = write back memory data, 0 = ALU result
//   ALUCtrl    out  4   ALU operation select
//   loadPC     out  1   PC update strobe, one pulse per completed instruction
//   MemRead    out  1   data memory read strobe
//   MemWrite   out  1   data memory write strobe
//   state_o    out  3   current FSM state (debug)
//   illegal    out  1   sticky error flag (illegal opcode or memory timeout)

module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic [3:0]  ALUCtrl,
    output logic        loadPC,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  state_o,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

    state_t      r_state;
    state_t      w_nextState;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic        r_bit30;
    logic [7:0]  r_waitCnt;
    logic [7:0]  w_waitNext;
    logic        r_illegal;

    logic        w_isR;
    logic        w_isIAlu;
    logic        w_isLoad;
    logic        w_isStore;
    logic        w_isBranch;
    logic        w_legal;
    logic [3:0]  w_aluOp;

    // Instruction bits this controller never looks at.
    logic        w_unused;
    assign w_unused = &{1'b0, instr[31], instr[29:15], instr[11:7]};

    // Class decode works on the captured fields only, so instr may change
    // freely after IF. Only BEQ/BNE count as legal branches.
    assign w_isR      = (r_opcode == OP_R);
    assign w_isIAlu   = (r_opcode == OP_IALU);
    assign w_isLoad   = (r_opcode == OP_LOAD);
    assign w_isStore  = (r_opcode == OP_STORE);
    assign w_isBranch = (r_opcode == OP_BRANCH) && (r_funct3[2:1] == 2'b00);
    assign w_legal    = w_isR | w_isIAlu | w_isLoad | w_isStore | w_isBranch;

    assign w_waitNext = r_waitCnt + 8'd1;

    // ALU operation for EX. Bit 30 picks SUB only for R-type, but it picks
    // SRA over SRL for both R-type and I-ALU (srai). sltu has no dedicated
    // code and shares SLT.
    always_comb begin
        w_aluOp = ALU_ADD;
        if (w_isBranch) begin
            w_aluOp = ALU_SUB;
        end else if (w_isR || w_isIAlu) begin
            case (r_funct3)
                3'b000:  w_aluOp = (w_isR && r_bit30) ? ALU_SUB : ALU_ADD;
                3'b001:  w_aluOp = ALU_SLL;
                3'b010:  w_aluOp = ALU_SLT;
                3'b011:  w_aluOp = ALU_SLT;
                3'b100:  w_aluOp = ALU_XOR;
                3'b101:  w_aluOp = r_bit30 ? ALU_SRA : ALU_SRL;
                3'b110:  w_aluOp = ALU_OR;
                default: w_aluOp = ALU_AND;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Field capture, MEM wait counter and the sticky error flag. The
    // counter runs only while MEM waits and clears whenever MEM is left.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opcode  <= 7'd0;
            r_funct3  <= 3'd0;
            r_bit30   <= 1'b0;
            r_waitCnt <= 8'd0;
            r_illegal <= 1'b0;
        end else begin
            if (r_state == S_IF) begin
                r_opcode <= instr[6:0];
                r_funct3 <= instr[14:12];
                r_bit30  <= instr[30];
            end
            if (w_nextState != S_MEM) begin
                r_waitCnt <= 8'd0;
            end else if ((r_state == S_MEM) && !mem_ready) begin
                r_waitCnt <= w_waitNext;
            end
            if (w_nextState == S_ERR) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next state and datapath controls. Strobes are suppressed while rst is
    // high so an abandoned instruction cannot write anything in that cycle.
    // mem_ready on the cycle the wait limit is reached still counts as a
    // completed access.
    always_comb begin
        w_nextState = r_state;
        PCSrc       = 1'b0;
        ALUSrc      = 1'b0;
        RegWrite    = 1'b0;
        MemToReg    = 1'b0;
        ALUCtrl     = ALU_ADD;
        loadPC      = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        case (r_state)
            S_IF: begin
                w_nextState = S_ID;
            end
            S_ID: begin
                w_nextState = w_legal ? S_EX : S_ERR;
            end
            S_EX: begin
                ALUCtrl = w_aluOp;
                ALUSrc  = w_isIAlu | w_isLoad | w_isStore;
                if (w_isBranch) begin
                    loadPC      = 1'b1;
                    PCSrc       = (r_funct3[0] == 1'b0) ? Zero : !Zero;
                    w_nextState = S_IF;
                end else if (w_isLoad || w_isStore) begin
                    w_nextState = S_MEM;
                end else begin
                    w_nextState = S_WB;
                end
            end
            S_MEM: begin
                MemRead  = w_isLoad;
                MemWrite = w_isStore;
                if (mem_ready) begin
                    loadPC      = w_isStore;
                    w_nextState = w_isLoad ? S_WB : S_IF;
                end else if (w_waitNext >= WAIT_LIMIT) begin
                    w_nextState = S_ERR;
                end
            end
            S_WB: begin
                RegWrite    = 1'b1;
                MemToReg    = w_isLoad;
                loadPC      = 1'b1;
                w_nextState = S_IF;
            end
            S_ERR: begin
                w_nextState = S_ERR;
            end
            default: begin
                w_nextState = S_ERR;
            end
        endcase
        if (rst) begin
            RegWrite = 1'b0;
            loadPC   = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
        end
    end

    assign state_o = r_state;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// ------------------
// Drives one instruction at a time through the controller and compares all
// outputs every cycle with a reference built from the instruction-class
// rules: which phases an instruction visits, which strobes each phase
// raises and which ALU operation the funct fields select.

module tb_multicycle_ctrl;

    localparam int MEM_WAIT_MAX = 15;
    localparam int NEVER        = 99;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;
    localparam logic [3:0] A_SRL = 4'b1000;
    localparam logic [3:0] A_SLL = 4'b1001;
    localparam logic [3:0] A_SRA = 4'b1010;
    localparam logic [3:0] A_XOR = 4'b1101;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic        mem_ready;
    logic        PCSrc;
    logic        ALUSrc;
    logic        RegWrite;
    logic        MemToReg;
    logic [3:0]  ALUCtrl;
    logic        loadPC;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  state_o;
    logic        illegal;

    int checkCount = 0;
    int passCount  = 0;

    logic [14:0] obsVec;

    multicycle_ctrl #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .PCSrc     (PCSrc),
        .ALUSrc    (ALUSrc),
        .RegWrite  (RegWrite),
        .MemToReg  (MemToReg),
        .ALUCtrl   (ALUCtrl),
        .loadPC    (loadPC),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .state_o   (state_o),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // All outputs packed in one vector so each cycle is one comparison.
    assign obsVec = {state_o, illegal, PCSrc, ALUSrc, RegWrite, MemToReg,
                     ALUCtrl, loadPC, MemRead, MemWrite};

    function automatic logic [14:0] expVec(input logic [2:0] st, input logic ill,
                                           input logic pcs, input logic alus,
                                           input logic rw, input logic m2r,
                                           input logic [3:0] alu, input logic lpc,
                                           input logic mr, input logic mw);
        return {st, ill, pcs, alus, rw, m2r, alu, lpc, mr, mw};
    endfunction

    // ALU operation table indexed by funct3; bit 30 selects SUB (R-type
    // only) and SRA (shift-right for both ALU classes).
    function automatic logic [3:0] modelAlu(input logic isRType, input logic [2:0] f3,
                                            input logic b30);
        logic [3:0] aluTable [8];
        aluTable = '{A_ADD, A_SLL, A_SLT, A_SLT, A_XOR, A_SRL, A_OR, A_AND};
        if (isRType && f3 == 3'd0 && b30) return A_SUB;
        if (f3 == 3'd5 && b30) return A_SRA;
        return aluTable[f3];
    endfunction

    task automatic checkOutput(input string tag, input logic [14:0] expected);
        checkCount++;
        assert (obsVec === expected) passCount++;
        else $error("[TB] FAIL %s: got %h, expected %h", tag, obsVec, expected);
    endtask

    // Runs one instruction from IF to completion. readyAt is the MEM cycle
    // index in which mem_ready rises (NEVER for a timeout); resetAt is the
    // MEM cycle index in which rst is pulsed (NEVER for none).
    task automatic applyStimulus(input string name, input logic [31:0] word,
                                 input logic zero, input int readyAt,
                                 input int resetAt);
        logic [6:0] op;
        logic [2:0] f3;
        logic       b30;
        logic       isR, isI, isL, isS, isB, legal, taken;
        logic [3:0] alu;
        bit         done;
        op    = word[6:0];
        f3    = word[14:12];
        b30   = word[30];
        isR   = (op == 7'b0110011);
        isI   = (op == 7'b0010011);
        isL   = (op == 7'b0000011);
        isS   = (op == 7'b0100011);
        isB   = (op == 7'b1100011) && (f3 == 3'd0 || f3 == 3'd1);
        legal = isR | isI | isL | isS | isB;
        taken = (f3 == 3'd0) ? zero : !zero;
        alu   = isB ? A_SUB : ((isL || isS) ? A_ADD : modelAlu(isR, f3, b30));

        @(negedge clk);
        rst = 1'b0; instr = word; Zero = zero; mem_ready = 1'($urandom);
        #1 checkOutput($sformatf("%s IF", name),
                       expVec(3'd0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0));

        @(negedge clk);
        instr = $urandom; mem_ready = 1'($urandom);
        #1 checkOutput($sformatf("%s ID", name),
                       expVec(3'd1, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0));

        if (!legal) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                instr = $urandom; mem_ready = 1'($urandom);
                #1 checkOutput($sformatf("%s ERR%0d", name, c),
                               expVec(3'd7, 1, 0, 0, 0, 0, A_ADD, 0, 0, 0));
            end
            @(negedge clk);
            rst = 1'b1;
            #1 checkOutput($sformatf("%s ERR rst", name),
                           expVec(3'd7, 1, 0, 0, 0, 0, A_ADD, 0, 0, 0));
            return;
        end

        @(negedge clk);
        instr = $urandom; mem_ready = 1'($urandom);
        #1 checkOutput($sformatf("%s EX", name),
                       expVec(3'd2, 0, isB ? taken : 1'b0, isI | isL | isS, 0, 0,
                              alu, isB, 0, 0));
        if (isB) return;

        if (isL || isS) begin
            done = 0;
            for (int k = 0; k < MEM_WAIT_MAX; k++) begin
                @(negedge clk);
                instr = $urandom;
                if (k == resetAt) begin
                    rst = 1'b1; mem_ready = 1'($urandom);
                    #1 checkOutput($sformatf("%s MEM%0d rst", name, k),
                                   expVec(3'd3, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0));
                    return;
                end
                mem_ready = (k == readyAt);
                #1 checkOutput($sformatf("%s MEM%0d", name, k),
                               expVec(3'd3, 0, 0, 0, 0, 0, A_ADD,
                                      isS && (k == readyAt), isL, isS));
                if (k == readyAt) begin
                    done = 1;
                    break;
                end
            end
            if (!done) begin
                @(negedge clk);
                instr = $urandom; mem_ready = 1'($urandom);
                #1 checkOutput($sformatf("%s timeout ERR", name),
                               expVec(3'd7, 1, 0, 0, 0, 0, A_ADD, 0, 0, 0));
                @(negedge clk);
                rst = 1'b1;
                #1 checkOutput($sformatf("%s timeout rst", name),
                               expVec(3'd7, 1, 0, 0, 0, 0, A_ADD, 0, 0, 0));
                return;
            end
            if (isS) return;
        end

        @(negedge clk);
        instr = $urandom; mem_ready = 1'($urandom);
        #1 checkOutput($sformatf("%s WB", name),
                       expVec(3'd4, 0, 0, 0, 1, isL, A_ADD, 1, 0, 0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] word;
        logic [6:0]  opList [6];
        int          kind;
        int          readyAt;
        int          resetAt;
        opList = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1111111};

        rst = 1'b1; instr = 32'd0; Zero = 1'b0; mem_ready = 1'b0;

        applyStimulus("add",      32'h002081B3, 1'b0, NEVER, NEVER);
        applyStimulus("sub",      32'h402081B3, 1'b0, NEVER, NEVER);
        applyStimulus("srai",     32'h4030D093, 1'b0, NEVER, NEVER);
        applyStimulus("beq z1",   32'h00208063, 1'b1, NEVER, NEVER);
        applyStimulus("beq z0",   32'h00208063, 1'b0, NEVER, NEVER);
        applyStimulus("bne z1",   32'h00209063, 1'b1, NEVER, NEVER);
        applyStimulus("lw wait3", 32'h0000A083, 1'b0, 3,     NEVER);
        applyStimulus("sw ready0",32'h0020A023, 1'b0, 0,     NEVER);
        applyStimulus("sw limit", 32'h0020A023, 1'b0, MEM_WAIT_MAX - 1, NEVER);
        applyStimulus("sw tmo",   32'h0020A023, 1'b0, NEVER, NEVER);
        applyStimulus("op 7F",    32'h0000007F, 1'b0, NEVER, NEVER);
        applyStimulus("bge",      32'h0020D063, 1'b0, NEVER, NEVER);
        applyStimulus("lw rst",   32'h0000A083, 1'b0, NEVER, 2);
        applyStimulus("or",       32'h0020E1B3, 1'b0, NEVER, NEVER);

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 5));
            word = $urandom;
            word[6:0] = opList[kind];
            if (kind == 5 && ($urandom_range(0, 1) == 1)) word[6:0] = 7'($urandom);
            readyAt = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 5));
            resetAt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : NEVER;
            applyStimulus($sformatf("rnd%0d %h", n, word), word, 1'($urandom),
                          readyAt, resetAt);
        end

        applyStimulus("final add", 32'h002081B3, 1'b0, NEVER, NEVER);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
